// File: rtl/complete_arbiter.sv
// Completion-path arbiter: N_FU functional units compete for N_WAY
// completion slots per cycle. Grants are issued combinationally in
// round-robin order and the granted tags are registered onto the slots,
// so a tag granted in cycle t is presented to the ROB/CDB in cycle t+1.

// One registered completion slot; clears on reset, otherwise reloads every cycle.
module complete_slot #(
   parameter int CDB_BITS = 6
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                d_valid,
   input  logic [CDB_BITS-1:0] d_tag,
   output logic                q_valid,
   output logic [CDB_BITS-1:0] q_tag
);

   // Capture this cycle's grant for the slot (empty slots load 0 / invalid).
   always_ff @(posedge clock) begin
      if (!reset) begin
         q_valid <= 1'b0;
         q_tag   <= '0;
      end else begin
         q_valid <= d_valid;
         q_tag   <= d_tag;
      end
   end

endmodule

module complete_arbiter #(
   parameter int N_FU     = 4,
   parameter int N_WAY    = 2,
   parameter int CDB_BITS = 6
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_FU-1:0]             req_valid,
   input  logic [N_FU*CDB_BITS-1:0]    req_tag,
   output logic [N_FU-1:0]             req_grant,
   output logic [N_WAY*CDB_BITS-1:0]   complete_dest_tag,
   output logic [N_WAY-1:0]            complete_valid,
   output logic [$clog2(N_FU):0]       pending_cnt
);

   localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;
   localparam int CNT_W = $clog2(N_FU) + 1;

   logic [PTR_W-1:0]                 rr_ptr;
   logic [PTR_W-1:0]                 rr_ptr_nxt;
   logic                             any_grant;
   logic [N_FU-1:0]                  grant;
   logic [N_WAY-1:0]                 slot_vld;
   logic [N_WAY-1:0][CDB_BITS-1:0]   slot_tag;
   logic [CNT_W-1:0]                 pend;

   // Round-robin scan from rr_ptr, wrapping once; the k-th eligible FU found
   // takes slot k until the slots run out. Tag 0 means "no completion" and is
   // never eligible even when valid is high.
   always_comb begin
      int n_elig;
      int n_grant;
      int last_idx;
      int idx;
      grant    = '0;
      slot_vld = '0;
      slot_tag = '0;
      n_elig   = 0;
      n_grant  = 0;
      last_idx = 0;
      idx      = 0;
      for (int k = 0; k < N_FU; k++) begin
         idx = (int'(rr_ptr) + k) % N_FU;
         if (req_valid[idx] && (req_tag[idx*CDB_BITS +: CDB_BITS] != '0)) begin
            n_elig++;
            if (n_grant < N_WAY) begin
               grant[idx]        = 1'b1;
               slot_vld[n_grant] = 1'b1;
               slot_tag[n_grant] = req_tag[idx*CDB_BITS +: CDB_BITS];
               n_grant++;
               last_idx = idx;
            end
         end
      end
      any_grant  = (n_grant != 0);
      rr_ptr_nxt = PTR_W'((last_idx + 1) % N_FU);
      pend       = CNT_W'(n_elig - n_grant);
   end

   // While reset is held, no transfer may be signalled to the FUs.
   assign req_grant   = reset ? grant : '0;
   assign pending_cnt = reset ? pend  : '0;

   // Pointer advances past the last granted FU; idle cycles leave it alone.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (any_grant) begin
         rr_ptr <= rr_ptr_nxt;
      end
   end

   for (genvar s = 0; s < N_WAY; s++) begin : g_slot
      complete_slot #(.CDB_BITS(CDB_BITS)) u_slot (
         .clock   (clock),
         .reset   (reset),
         .d_valid (slot_vld[s]),
         .d_tag   (slot_tag[s]),
         .q_valid (complete_valid[s]),
         .q_tag   (complete_dest_tag[s*CDB_BITS +: CDB_BITS])
      );
   end

endmodule

// File: tb/tb_complete_arbiter.sv
// Bench for complete_arbiter (N_FU=4, N_WAY=2, CDB_BITS=6).
// Inputs change 1ns after posedge; everything is checked at negedge.
module tb_complete_arbiter;

   localparam int NF = 4;
   localparam int NW = 2;
   localparam int CB = 6;

   logic                 clock;
   logic                 reset;
   logic [NF-1:0]        req_valid;
   logic [NF*CB-1:0]     req_tag;
   logic [NF-1:0]        req_grant;
   logic [NW*CB-1:0]     complete_dest_tag;
   logic [NW-1:0]        complete_valid;
   logic [$clog2(NF):0]  pending_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   complete_arbiter #(.N_FU(NF), .N_WAY(NW), .CDB_BITS(CB)) dut (
      .clock             (clock),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_tag           (req_tag),
      .req_grant         (req_grant),
      .complete_dest_tag (complete_dest_tag),
      .complete_valid    (complete_valid),
      .pending_cnt       (pending_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [NF-1:0] v, input int t0, input int t1, input int t2, input int t3);
      req_valid = v;
      req_tag   = {CB'(t3), CB'(t2), CB'(t1), CB'(t0)};
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // ---------------- reference model ----------------
   // State: pointer and the slot contents the DUT must currently show.
   int               m_ptr = 0;
   logic [NW*CB-1:0] m_tag = '0;
   logic [NW-1:0]    m_vld = '0;

   always @(negedge clock) begin
      int               q[$];
      logic [NF-1:0]    e_grant;
      logic [NW*CB-1:0] n_tag;
      logic [NW-1:0]    n_vld;
      int               ng;
      int               e_pend;
      int               tg;
      chk("slot_tags", complete_dest_tag, m_tag);
      chk("slot_valid", complete_valid, m_vld);
      q = {};
      for (int k = 0; k < NF; k++) begin
         int i;
         i = (m_ptr + k) % NF;
         tg = int'(req_tag[i*CB +: CB]);
         if (req_valid[i] && tg != 0) q.push_back(i);
      end
      ng      = (q.size() < NW) ? q.size() : NW;
      e_grant = '0;
      n_tag   = '0;
      n_vld   = '0;
      for (int s = 0; s < ng; s++) begin
         e_grant[q[s]]     = 1'b1;
         n_tag[s*CB +: CB] = req_tag[q[s]*CB +: CB];
         n_vld[s]          = 1'b1;
      end
      e_pend = q.size() - ng;
      if (!reset) begin
         chk("grant_rst", req_grant, '0);
         chk("pend_rst", pending_cnt, '0);
         m_tag = '0;
         m_vld = '0;
         m_ptr = 0;
      end else begin
         chk("grant", req_grant, e_grant);
         chk("pending", pending_cnt, e_pend);
         m_tag = n_tag;
         m_vld = n_vld;
         if (ng > 0) m_ptr = (q[ng-1] + 1) % NF;
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      int cnt[NF];
      int wait_c[NF];
      int max_wait;
      reset = 1'b0;
      drive(4'b1111, 1, 2, 3, 4);

      // 1: reset with everyone requesting
      @(negedge clock);
      chk("t1_grant", req_grant, 4'b0000);
      chk("t1_pend", pending_cnt, 0);
      chk("t1_valid", complete_valid, 2'b00);
      chk("t1_tags", complete_dest_tag, 0);
      chk("t1_ptr", dut.rr_ptr, 0);

      // 2: four requesters, two slots
      next_cycle();
      reset = 1'b1;
      drive(4'b1111, 5, 6, 7, 8);
      @(negedge clock);
      chk("t2_grant0", req_grant, 4'b0011);
      chk("t2_pend0", pending_cnt, 2);
      next_cycle();
      drive(4'b1100, 0, 0, 7, 8);
      @(negedge clock);
      chk("t2_grant1", req_grant, 4'b1100);
      chk("t2_slots1", complete_dest_tag, {6'd6, 6'd5});
      chk("t2_valid1", complete_valid, 2'b11);
      next_cycle();
      drive(4'b0000, 0, 0, 0, 0);
      @(negedge clock);
      chk("t2_slots2", complete_dest_tag, {6'd8, 6'd7});
      chk("t2_ptr", dut.rr_ptr, 0);

      // 3: single requester
      next_cycle();
      drive(4'b0100, 0, 0, 9, 0);
      @(negedge clock);
      chk("t3_grant", req_grant, 4'b0100);
      next_cycle();
      drive(4'b0000, 0, 0, 0, 0);
      @(negedge clock);
      chk("t3_slots", complete_dest_tag, {6'd0, 6'd9});
      chk("t3_valid", complete_valid, 2'b01);
      chk("t3_ptr", dut.rr_ptr, 3);

      // 4: wrap-around from FU3 to FU0
      next_cycle();
      drive(4'b1001, 4, 0, 0, 11);
      @(negedge clock);
      chk("t4_grant", req_grant, 4'b1001);
      next_cycle();
      drive(4'b0000, 0, 0, 0, 0);
      @(negedge clock);
      chk("t4_slots", complete_dest_tag, {6'd4, 6'd11});
      chk("t4_ptr", dut.rr_ptr, 1);

      // 5: fairness under saturation
      for (int i = 0; i < NF; i++) begin cnt[i] = 0; wait_c[i] = 0; end
      max_wait = 0;
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         drive(4'b1111, 20, 21, 22, 23);
         @(negedge clock);
         chk("t5_pend", pending_cnt, 2);
         for (int i = 0; i < NF; i++) begin
            if (req_grant[i]) begin
               cnt[i]++;
               wait_c[i] = 0;
            end else begin
               wait_c[i]++;
               if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
         end
      end
      for (int i = 0; i < NF; i++) chk($sformatf("t5_cnt_fu%0d", i), cnt[i], 4);
      n_tests++;
      if (max_wait > 2) begin
         n_fail++;
         $display("FAIL t5_max_wait: got %0d expected <= 2", max_wait);
      end
      next_cycle();
      drive(4'b0000, 0, 0, 0, 0);
      @(negedge clock);

      // 6: valid with null tag is ignored
      next_cycle();
      drive(4'b0110, 0, 0, 3, 0);
      @(negedge clock);
      chk("t6_grant", req_grant, 4'b0100);
      chk("t6_pend", pending_cnt, 0);
      next_cycle();
      drive(4'b0000, 0, 0, 0, 0);
      @(negedge clock);
      chk("t6_valid", complete_valid, 2'b01);
      chk("t6_slots", complete_dest_tag, {6'd0, 6'd3});

      // 7: reset mid-operation, requests stay up
      next_cycle();
      drive(4'b1111, 5, 6, 7, 8);
      @(negedge clock);
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      chk("t7_grant_rst", req_grant, 4'b0000);
      next_cycle();
      reset = 1'b1;
      @(negedge clock);
      chk("t7_valid", complete_valid, 2'b00);
      chk("t7_grant", req_grant, 4'b0011);
      next_cycle();
      drive(4'b0000, 0, 0, 0, 0);
      @(negedge clock);
      chk("t7_slots", complete_dest_tag, {6'd6, 6'd5});

      next_cycle();
      @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
